// File: rtl/step_mon_pkg.sv
// ----------------------------------------------------------------------------
// step_mon_pkg
// Shared types and pattern decoding for the stepper coil bus monitor.
//   state_e        : monitor FSM states (SYNC, TRACK)
//   N / IDX_W      : number of sequence positions and index width
//   decode_pattern : coil pattern -> {valid, index}
// Build option: define HALF_STEP_EN for the 8-position half-step sequence;
// the default build decodes the 4-position full-step sequence only.
// ----------------------------------------------------------------------------
package step_mon_pkg;

   typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} state_e;

   typedef logic [3:0] phase_t;

`ifdef HALF_STEP_EN
   localparam int N = 8;
`else
   localparam int N = 4;
`endif
   localparam int IDX_W = $clog2(N);

   typedef logic [IDX_W-1:0] idx_t;

   typedef struct packed {
      logic valid;
      idx_t idx;
   } decode_t;

   // Coil patterns: single-coil (full step) and two-coil (half step only)
   localparam phase_t PAT_OFF = 4'b0000;
   localparam phase_t PAT_A   = 4'b0001;
   localparam phase_t PAT_AB  = 4'b0011;
   localparam phase_t PAT_B   = 4'b0010;
   localparam phase_t PAT_BC  = 4'b0110;
   localparam phase_t PAT_C   = 4'b0100;
   localparam phase_t PAT_CD  = 4'b1100;
   localparam phase_t PAT_D   = 4'b1000;
   localparam phase_t PAT_DA  = 4'b1001;

   // PAT_OFF decodes as invalid here; callers treat it separately.
   function automatic decode_t decode_pattern(input phase_t pat);
      decode_t d;
      d.valid = 1'b1;
      d.idx   = '0;
`ifdef HALF_STEP_EN
      case (pat)
         PAT_A:   d.idx = idx_t'(0);
         PAT_AB:  d.idx = idx_t'(1);
         PAT_B:   d.idx = idx_t'(2);
         PAT_BC:  d.idx = idx_t'(3);
         PAT_C:   d.idx = idx_t'(4);
         PAT_CD:  d.idx = idx_t'(5);
         PAT_D:   d.idx = idx_t'(6);
         PAT_DA:  d.idx = idx_t'(7);
         default: d.valid = 1'b0;
      endcase
`else
      case (pat)
         PAT_A:   d.idx = idx_t'(0);
         PAT_B:   d.idx = idx_t'(1);
         PAT_C:   d.idx = idx_t'(2);
         PAT_D:   d.idx = idx_t'(3);
         default: d.valid = 1'b0;
      endcase
`endif
      return d;
   endfunction

endpackage

// File: rtl/step_mon_filter.sv
// ----------------------------------------------------------------------------
// step_mon_filter
// Two-flop synchronizer followed by a stability filter for the coil pattern.
//   clk, rst_n : clock, asynchronous active-low reset
//   phase_in   : raw coil pattern from the pads (asynchronous)
//   acc_pat    : last accepted (stable) pattern
//   accept     : one-cycle strobe when acc_pat takes a new value
// A pattern is accepted once STABLE_CYC consecutive synchronized samples agree
// and it differs from the pattern accepted before.
// ----------------------------------------------------------------------------
module step_mon_filter
   import step_mon_pkg::*;
#(
   parameter int STABLE_CYC = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   input  phase_t phase_in,
   output phase_t acc_pat,
   output logic   accept
);

   localparam logic [7:0] STABLE = 8'(STABLE_CYC);

   phase_t     sync1_q, sync2_q, prev_q;
   phase_t     acc_pat_q, acc_pat_d;
   logic [7:0] cnt_q, cnt_d;
   logic       accept_q, accept_d;

   // NOTE: every variable gets a value on every path through this block,
   // which keeps it purely combinational (no latch).
   always_comb begin
      // A new sample value counts as the first of its run.
      if (sync2_q != prev_q) begin
         cnt_d = 8'd1;
      end else if (cnt_q < STABLE) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = cnt_q;
      end
      accept_d  = (cnt_d == STABLE) && (sync2_q != acc_pat_q);
      acc_pat_d = accept_d ? sync2_q : acc_pat_q;
   end

   // NOTE: non-blocking assignments, so each stage takes the value the
   // previous stage held before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= PAT_OFF;
         sync2_q   <= PAT_OFF;
         prev_q    <= PAT_OFF;
         cnt_q     <= '0;
         accept_q  <= 1'b0;
         acc_pat_q <= PAT_OFF;
      end else begin
         sync1_q   <= phase_in;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         cnt_q     <= cnt_d;
         accept_q  <= accept_d;
         acc_pat_q <= acc_pat_d;
      end
   end

   assign acc_pat = acc_pat_q;
   assign accept  = accept_q;

endmodule

// File: rtl/step_seq_monitor.sv
// ----------------------------------------------------------------------------
// step_seq_monitor
// Receive-side checker for the 4-phase stepper coil bus.
//   clk, rst_n  : clock, asynchronous active-low reset
//   phase_in    : coil pattern from pads (asynchronous)
//   clear       : synchronous clear of position, seq_err and err_cnt
//   step_pulse  : one-cycle pulse per legal step
//   step_dir    : direction of last legal step (1 = index increment)
//   position    : signed step count (wraps in two's complement)
//   moving      : last step younger than IDLE_TO cycles
//   locked      : FSM in TRACK
//   seq_err     : sticky illegal-transition flag
//   err_cnt     : saturating illegal-transition count
// Build option: HALF_STEP_EN selects the 8-position half-step sequence.
// ----------------------------------------------------------------------------
module step_seq_monitor
   import step_mon_pkg::*;
#(
   parameter int POS_W      = 16,
   parameter int STABLE_CYC = 4,
   parameter int IDLE_TO    = 1000,
   parameter int ERR_W      = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [3:0]              phase_in,
   input  logic                    clear,
   output logic                    step_pulse,
   output logic                    step_dir,
   output logic signed [POS_W-1:0] position,
   output logic                    moving,
   output logic                    locked,
   output logic                    seq_err,
   output logic [ERR_W-1:0]        err_cnt
);

   localparam int               IDLE_W   = $clog2(IDLE_TO + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TO);

   phase_t acc_pat;
   logic   accept;

   step_mon_filter #(.STABLE_CYC(STABLE_CYC)) u_filter (
      .clk      (clk),
      .rst_n    (rst_n),
      .phase_in (phase_in),
      .acc_pat  (acc_pat),
      .accept   (accept)
   );

   state_e                  state_q, state_d;
   idx_t                    ref_q, ref_d;
   logic                    step_pulse_q, step_pulse_d;
   logic                    step_dir_q, step_dir_d;
   logic signed [POS_W-1:0] position_q, position_d;
   logic                    seq_err_q, seq_err_d;
   logic [ERR_W-1:0]        err_cnt_q, err_cnt_d;
   logic [IDLE_W-1:0]       idle_q, idle_d;
   logic                    moving_q, moving_d;

   decode_t dec;
   idx_t    idx_fwd, idx_bwd;
   logic    err_ev;

   always_comb begin
      dec          = decode_pattern(acc_pat);
      // Index arithmetic wraps modulo N because N is a power of two.
      idx_fwd      = ref_q + idx_t'(1);
      idx_bwd      = ref_q - idx_t'(1);
      state_d      = state_q;
      ref_d        = ref_q;
      step_pulse_d = 1'b0;
      step_dir_d   = step_dir_q;
      position_d   = position_q;
      err_ev       = 1'b0;

      // Released coils (PAT_OFF) keep state and reference untouched.
      if (accept && (acc_pat != PAT_OFF)) begin
         if (state_q == SYNC) begin
            if (dec.valid) begin
               ref_d   = dec.idx;
               state_d = TRACK;
            end
         end else begin
            if (!dec.valid) begin
               err_ev  = 1'b1;
               state_d = SYNC;
            end else if (dec.idx == idx_fwd) begin
               step_pulse_d = 1'b1;
               step_dir_d   = 1'b1;
               position_d   = position_q + POS_W'(1);
               ref_d        = dec.idx;
            end else if (dec.idx == idx_bwd) begin
               step_pulse_d = 1'b1;
               step_dir_d   = 1'b0;
               position_d   = position_q - POS_W'(1);
               ref_d        = dec.idx;
            end else if (dec.idx != ref_q) begin
               // Jump: resynchronise on the new index without leaving TRACK.
               err_ev = 1'b1;
               ref_d  = dec.idx;
            end
         end
      end

      seq_err_d = seq_err_q | err_ev;
      err_cnt_d = (err_ev && (err_cnt_q != '1)) ? err_cnt_q + ERR_W'(1) : err_cnt_q;

      // clear overrides any same-cycle step or error accounting.
      if (clear) begin
         position_d = '0;
         seq_err_d  = 1'b0;
         err_cnt_d  = '0;
      end

      if (step_pulse_d) begin
         idle_d = '0;
      end else if (idle_q < IDLE_MAX) begin
         idle_d = idle_q + IDLE_W'(1);
      end else begin
         idle_d = idle_q;
      end
      moving_d = (idle_d < IDLE_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= SYNC;
         ref_q        <= '0;
         step_pulse_q <= 1'b0;
         step_dir_q   <= 1'b0;
         position_q   <= '0;
         seq_err_q    <= 1'b0;
         err_cnt_q    <= '0;
         idle_q       <= IDLE_MAX;
         moving_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         ref_q        <= ref_d;
         step_pulse_q <= step_pulse_d;
         step_dir_q   <= step_dir_d;
         position_q   <= position_d;
         seq_err_q    <= seq_err_d;
         err_cnt_q    <= err_cnt_d;
         idle_q       <= idle_d;
         moving_q     <= moving_d;
      end
   end

   assign step_pulse = step_pulse_q;
   assign step_dir   = step_dir_q;
   assign position   = position_q;
   assign moving     = moving_q;
   assign locked     = (state_q == TRACK);
   assign seq_err    = seq_err_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_step_seq_monitor.sv
// ----------------------------------------------------------------------------
// tb_step_seq_monitor
// Self-checking bench for step_seq_monitor. A behavioural model tracks the
// accepted pattern sequence as table positions and applies the stepping rules
// with modular arithmetic. Honours HALF_STEP_EN like the design.
// ----------------------------------------------------------------------------
module tb_step_seq_monitor;

   localparam int POS_W   = 16;
   localparam int STABLE  = 4;
   localparam int IDLE_TO = 1000;
   localparam int ERR_W   = 8;
   localparam int HOLD    = STABLE + 6;
   localparam int LAT     = 2 + STABLE + 1;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

`ifdef HALF_STEP_EN
   localparam int N = 8;
`else
   localparam int N = 4;
`endif

   typedef logic [26:0] vec_t;

   logic                    clk;
   logic                    rst_n;
   logic [3:0]              phase_in;
   logic                    clear;
   logic                    step_pulse;
   logic                    step_dir;
   logic signed [POS_W-1:0] position;
   logic                    moving;
   logic                    locked;
   logic                    seq_err;
   logic [ERR_W-1:0]        err_cnt;

   step_seq_monitor #(
      .POS_W      (POS_W),
      .STABLE_CYC (STABLE),
      .IDLE_TO    (IDLE_TO),
      .ERR_W      (ERR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .phase_in   (phase_in),
      .clear      (clear),
      .step_pulse (step_pulse),
      .step_dir   (step_dir),
      .position   (position),
      .moving     (moving),
      .locked     (locked),
      .seq_err    (seq_err),
      .err_cnt    (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int obs_pulses = 0;

   // Count pulses just after each active edge, away from the edge itself.
   always @(posedge clk) begin
      #1;
      if (step_pulse === 1'b1) obs_pulses++;
   end

   // ---------------- reference model ----------------
   logic [3:0]  tbl [N];
   logic [3:0]  m_acc;
   logic [15:0] m_pos;
   bit          m_locked, m_err, m_dir;
   int          m_ref, m_cnt, m_pulses;

   function automatic int find_idx(input logic [3:0] p);
      for (int i = 0; i < N; i++) if (tbl[i] == p) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_acc = 4'b0000; m_pos = '0; m_locked = 0; m_err = 0; m_dir = 0;
      m_ref = 0; m_cnt = 0;
   endtask

   task automatic model_error();
      m_err = 1;
      if (m_cnt < ERR_MAX) m_cnt++;
   endtask

   task automatic model_accept(input logic [3:0] p);
      int idx, d;
      if (p == m_acc) return;
      m_acc = p;
      if (p == 4'b0000) return;
      idx = find_idx(p);
      if (!m_locked) begin
         if (idx >= 0) begin m_locked = 1; m_ref = idx; end
      end else if (idx < 0) begin
         model_error(); m_locked = 0;
      end else begin
         d = (idx - m_ref + N) % N;
         if (d == 1) begin
            m_pos = m_pos + 16'd1; m_dir = 1; m_pulses++; m_ref = idx;
         end else if (d == N - 1) begin
            m_pos = m_pos - 16'd1; m_dir = 0; m_pulses++; m_ref = idx;
         end else if (d != 0) begin
            model_error(); m_ref = idx;
         end
      end
   endtask

   task automatic model_clear();
      m_pos = '0; m_err = 0; m_cnt = 0;
   endtask

   function automatic vec_t dut_vec();
      return {position, seq_err, err_cnt, locked, step_dir};
   endfunction

   function automatic vec_t model_vec();
      return {m_pos, m_err, m_cnt[ERR_W-1:0], m_locked, m_dir};
   endfunction

   function automatic string show(input vec_t v);
      return $sformatf("pos=%0d err=%b cnt=%0d lock=%b dir=%b",
                       $signed(v[26:11]), v[10], v[9:2], v[1], v[0]);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic [3:0] p, input int hold);
      phase_in = p;
      repeat (hold) @(negedge clk);
      if (hold >= STABLE + 3) model_accept(p);
   endtask

   task automatic apply_reset();
      phase_in = 4'b0000;
      clear    = 1'b0;
      rst_n    = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_clear();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({position, step_pulse, step_dir, moving, locked, seq_err, err_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_active: got %s pulse=%b moving=%b, required all zero",
                  show(dut_vec()), step_pulse, moving);
      end
      rst_n = 1'b1;
      model_reset();
      repeat (HOLD) @(negedge clk);
      n_checks++;
      if ({position, step_pulse, step_dir, moving, locked, seq_err, err_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_idle: got %s pulse=%b moving=%b, required all zero",
                  show(dut_vec()), step_pulse, moving);
      end
   endtask

   task automatic test_forward();
      int lat;
      apply_reset();
      drive(tbl[0], HOLD);
      n_checks++;
      if (dut_vec() !== model_vec() || locked !== 1'b1 || obs_pulses != m_pulses) begin
         n_fail++;
         $display("FAIL fwd_lock: got %s pulses=%0d, required %s pulses=%0d",
                  show(dut_vec()), obs_pulses, show(model_vec()), m_pulses);
      end
      phase_in = tbl[1];
      lat = 0;
      for (int i = 1; i <= HOLD; i++) begin
         @(negedge clk);
         if (step_pulse === 1'b1 && lat == 0) lat = i;
      end
      model_accept(tbl[1]);
      n_checks++;
      if (lat != LAT) begin
         n_fail++;
         $display("FAIL fwd_latency: got %0d cycles, required %0d", lat, LAT);
      end
      for (int k = 2; k <= N; k++) drive(tbl[k % N], HOLD);
      n_checks++;
      if (position !== POS_W'(N) || step_dir !== 1'b1 || dut_vec() !== model_vec()
          || obs_pulses != m_pulses) begin
         n_fail++;
         $display("FAIL fwd_walk: got %s pulses=%0d, required %s pulses=%0d",
                  show(dut_vec()), obs_pulses, show(model_vec()), m_pulses);
      end
   endtask

   task automatic test_backward();
      apply_reset();
      drive(tbl[0], HOLD);
      drive(tbl[N-1], HOLD);
      drive(tbl[N-2], HOLD);
      n_checks++;
      if (position !== 16'hFFFE || step_dir !== 1'b0 || dut_vec() !== model_vec()
          || obs_pulses != m_pulses) begin
         n_fail++;
         $display("FAIL backward: got %s pulses=%0d, required %s pulses=%0d",
                  show(dut_vec()), obs_pulses, show(model_vec()), m_pulses);
      end
   endtask

   task automatic test_glitch();
      apply_reset();
      drive(tbl[0], HOLD);
      phase_in = tbl[1];
      repeat (STABLE - 1) @(negedge clk);
      phase_in = tbl[0];
      repeat (HOLD) @(negedge clk);
      n_checks++;
      if (dut_vec() !== model_vec() || seq_err !== 1'b0 || position !== '0
          || obs_pulses != m_pulses) begin
         n_fail++;
         $display("FAIL glitch: got %s pulses=%0d, required %s pulses=%0d",
                  show(dut_vec()), obs_pulses, show(model_vec()), m_pulses);
      end
   endtask

   task automatic test_jump();
      apply_reset();
      drive(tbl[0], HOLD);
      drive(tbl[2], HOLD);
      n_checks++;
      if (seq_err !== 1'b1 || err_cnt !== ERR_W'(1) || position !== '0 || locked !== 1'b1
          || dut_vec() !== model_vec()) begin
         n_fail++;
         $display("FAIL jump_err: got %s, required %s", show(dut_vec()), show(model_vec()));
      end
      drive(tbl[3], HOLD);
      n_checks++;
      if (position !== POS_W'(1) || dut_vec() !== model_vec() || obs_pulses != m_pulses) begin
         n_fail++;
         $display("FAIL jump_recover: got %s pulses=%0d, required %s pulses=%0d",
                  show(dut_vec()), obs_pulses, show(model_vec()), m_pulses);
      end
   endtask

   task automatic test_illegal_clear();
      logic [3:0] ill;
`ifdef HALF_STEP_EN
      ill = 4'b0101;
`else
      ill = 4'b0110;
`endif
      apply_reset();
      drive(tbl[0], HOLD);
      drive(tbl[1], HOLD);
      drive(ill, HOLD);
      n_checks++;
      if (seq_err !== 1'b1 || locked !== 1'b0 || dut_vec() !== model_vec()) begin
         n_fail++;
         $display("FAIL illegal: got %s, required %s", show(dut_vec()), show(model_vec()));
      end
      pulse_clear();
      n_checks++;
      if (seq_err !== 1'b0 || err_cnt !== '0 || position !== '0 || locked !== 1'b0
          || dut_vec() !== model_vec()) begin
         n_fail++;
         $display("FAIL clear: got %s, required %s", show(dut_vec()), show(model_vec()));
      end
      drive(tbl[0], HOLD);
      n_checks++;
      if (locked !== 1'b1 || dut_vec() !== model_vec()) begin
         n_fail++;
         $display("FAIL relock: got %s, required %s", show(dut_vec()), show(model_vec()));
      end
   endtask

   task automatic test_clear_collision();
      apply_reset();
      drive(tbl[0], HOLD);
      phase_in = tbl[1];
      repeat (LAT - 1) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_accept(tbl[1]);
      model_clear();
      n_checks++;
      if (step_pulse !== 1'b1 || step_dir !== 1'b1 || position !== '0) begin
         n_fail++;
         $display("FAIL clear_collision: got pulse=%b dir=%b pos=%0d, required pulse=1 dir=1 pos=0",
                  step_pulse, step_dir, position);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (dut_vec() !== model_vec() || obs_pulses != m_pulses) begin
         n_fail++;
         $display("FAIL clear_collision_after: got %s pulses=%0d, required %s pulses=%0d",
                  show(dut_vec()), obs_pulses, show(model_vec()), m_pulses);
      end
   endtask

   task automatic test_zero_release();
      apply_reset();
      drive(tbl[0], HOLD);
      drive(tbl[1], HOLD);
      drive(4'b0000, HOLD);
      drive(tbl[1], HOLD);
      n_checks++;
      if (position !== POS_W'(1) || locked !== 1'b1 || seq_err !== 1'b0
          || dut_vec() !== model_vec() || obs_pulses != m_pulses) begin
         n_fail++;
         $display("FAIL zero_same: got %s pulses=%0d, required %s pulses=%0d",
                  show(dut_vec()), obs_pulses, show(model_vec()), m_pulses);
      end
      drive(tbl[2], HOLD);
      n_checks++;
      if (position !== POS_W'(2) || dut_vec() !== model_vec()) begin
         n_fail++;
         $display("FAIL zero_resume: got %s, required %s", show(dut_vec()), show(model_vec()));
      end
   endtask

   task automatic test_moving();
      int found, idle;
      apply_reset();
      drive(tbl[0], HOLD);
      phase_in = tbl[1];
      found = 0;
      for (int i = 0; i < 4 * HOLD && found == 0; i++) begin
         @(negedge clk);
         if (step_pulse === 1'b1) found = 1;
      end
      model_accept(tbl[1]);
      n_checks++;
      if (found == 0 || moving !== 1'b1) begin
         n_fail++;
         $display("FAIL moving_start: got pulse_seen=%0d moving=%b, required 1 1", found, moving);
      end
      idle = 0;
      for (int j = 1; j <= IDLE_TO + 50 && idle == 0; j++) begin
         @(negedge clk);
         if (moving !== 1'b1) idle = j;
      end
      n_checks++;
      if (idle != IDLE_TO) begin
         n_fail++;
         $display("FAIL moving_timeout: got drop after %0d cycles, required %0d", idle, IDLE_TO);
      end
   endtask

   task automatic test_err_saturate();
      apply_reset();
      drive(tbl[0], HOLD);
      for (int i = 0; i < ERR_MAX + 5; i++) drive((i % 2 == 0) ? tbl[2] : tbl[0], STABLE + 4);
      n_checks++;
      if (err_cnt !== ERR_W'(ERR_MAX) || seq_err !== 1'b1 || dut_vec() !== model_vec()) begin
         n_fail++;
         $display("FAIL err_saturate: got %s, required %s", show(dut_vec()), show(model_vec()));
      end
   endtask

   task automatic test_half_step();
      apply_reset();
`ifdef HALF_STEP_EN
      drive(4'b0001, HOLD);
      drive(4'b0011, HOLD);
      drive(4'b0010, HOLD);
      n_checks++;
      if (position !== POS_W'(2) || step_dir !== 1'b1 || dut_vec() !== model_vec()) begin
         n_fail++;
         $display("FAIL half_fwd: got %s, required %s", show(dut_vec()), show(model_vec()));
      end
      drive(4'b0011, HOLD);
      drive(4'b0001, HOLD);
      drive(4'b0010, HOLD);
      n_checks++;
      if (seq_err !== 1'b1 || err_cnt !== ERR_W'(1) || dut_vec() !== model_vec()) begin
         n_fail++;
         $display("FAIL half_jump: got %s, required %s", show(dut_vec()), show(model_vec()));
      end
`else
      drive(4'b0001, HOLD);
      drive(4'b0011, HOLD);
      n_checks++;
      if (seq_err !== 1'b1 || locked !== 1'b0 || dut_vec() !== model_vec()) begin
         n_fail++;
         $display("FAIL two_coil_track: got %s, required %s", show(dut_vec()), show(model_vec()));
      end
      drive(4'b1001, HOLD);
      n_checks++;
      if (err_cnt !== ERR_W'(1) || locked !== 1'b0 || dut_vec() !== model_vec()) begin
         n_fail++;
         $display("FAIL two_coil_sync: got %s, required %s", show(dut_vec()), show(model_vec()));
      end
`endif
   endtask

   task automatic test_reset_mid();
      apply_reset();
      drive(tbl[0], HOLD);
      drive(tbl[1], HOLD);
      drive(tbl[2], HOLD);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({position, step_pulse, step_dir, moving, locked, seq_err, err_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: got %s pulse=%b moving=%b, required all zero",
                  show(dut_vec()), step_pulse, moving);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      drive(phase_in, HOLD);
      n_checks++;
      if (locked !== 1'b1 || position !== '0 || dut_vec() !== model_vec()
          || obs_pulses != m_pulses) begin
         n_fail++;
         $display("FAIL reset_relock: got %s pulses=%0d, required %s pulses=%0d",
                  show(dut_vec()), obs_pulses, show(model_vec()), m_pulses);
      end
   endtask

   task automatic test_random();
      logic [3:0] p, cur;
      int act;
      apply_reset();
      drive(tbl[0], HOLD);
      for (int it = 0; it < 80; it++) begin
         act = $urandom_range(0, 9);
         if (act <= 5) begin
            if (m_locked) p = tbl[(m_ref + ((act % 2 == 0) ? 1 : N - 1)) % N];
            else          p = tbl[$urandom_range(0, N - 1)];
            drive(p, $urandom_range(STABLE + 3, STABLE + 8));
         end else if (act == 6) begin
            drive(tbl[$urandom_range(0, N - 1)], $urandom_range(STABLE + 3, STABLE + 8));
         end else if (act == 7) begin
            drive(4'b0000, $urandom_range(STABLE + 3, STABLE + 8));
         end else if (act == 8) begin
            cur = phase_in;
            p   = tbl[$urandom_range(0, N - 1)];
            if (p == cur) p = 4'b1111;
            phase_in = p;
            repeat ($urandom_range(1, STABLE - 1)) @(negedge clk);
            phase_in = cur;
            repeat (HOLD) @(negedge clk);
         end else begin
            do p = 4'($urandom_range(1, 15)); while (find_idx(p) >= 0);
            drive(p, $urandom_range(STABLE + 3, STABLE + 8));
         end
         if ($urandom_range(0, 7) == 0) pulse_clear();
         n_checks++;
         if (dut_vec() !== model_vec() || obs_pulses != m_pulses) begin
            n_fail++;
            $display("FAIL random_%0d act=%0d: got %s pulses=%0d, required %s pulses=%0d",
                     it, act, show(dut_vec()), obs_pulses, show(model_vec()), m_pulses);
         end
      end
   endtask

   // ---------------- sequencing ----------------
   initial begin
`ifdef HALF_STEP_EN
      tbl = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};
`else
      tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
      m_pulses = 0;
      model_reset();
      rst_n    = 1'b0;
      phase_in = 4'b0000;
      clear    = 1'b0;
      test_reset();
      test_forward();
      test_backward();
      test_glitch();
      test_jump();
      test_illegal_clear();
      test_clear_collision();
      test_zero_release();
      test_moving();
      test_err_saturate();
      test_half_step();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
